// File: rtl/muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_hilo_unit
// Description : Multi-cycle multiply/divide unit holding the architectural
//               HI/LO registers. Sits beside the single-cycle ALU in EX and
//               takes the same X/Y operands. MULT/MULTU use a radix-2
//               shift-add multiplier and DIV/DIVU use a radix-2 restoring
//               divider; both work on operand magnitudes and apply the sign
//               in a final FIN cycle. MTHI/MTLO write HI/LO directly.
//
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous reset, active low
//               X      - dividend / multiplicand / MTHI-MTLO data
//               Y      - divisor / multiplier
//               Op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//                        6-7 reserved (ignored)
//               Start  - request, sampled only while Busy=0
//               Flush  - abort in-flight op / drop a simultaneous Start
//               Busy   - iterative op in progress (hazard unit stalls on it)
//               Done   - one-cycle pulse after a mult/div wrote HI/LO
//               HI, LO - architectural HI/LO registers
//
// Config      : MULDIV_FAST_MULT_EN - when defined, MULT/MULTU are computed
//               combinationally and written at the accept edge (Busy stays
//               low, Done pulses the next cycle). DIV/DIVU stay iterative.
//
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_hilo_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic [2:0]  Op,
    input  logic        Start,
    input  logic        Flush,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // Iterations per operation; fixed by the 32-bit datapath.
    localparam int ITER = 32;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  count;
    // acc_hi : multiply partial-product high word / divide partial remainder
    // acc_lo : multiplier being shifted out / dividend shifted out, quotient in
    // opnd_b : multiplicand magnitude / divisor magnitude
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] opnd_b;
    logic        is_div;
    logic        neg_q;      // negate product / quotient in FIN
    logic        neg_r;      // negate remainder in FIN (dividend was negative)
    logic        div_zero;   // divisor was zero

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic        start_ok;
    logic        md_req;
    logic        iter_req;
    logic        signed_op;
    logic [31:0] abs_x;
    logic [31:0] abs_y;

    // Flush in IDLE drops any Start, including MTHI/MTLO.
    assign start_ok  = Start && !Flush && (state == ST_IDLE);
    assign md_req    = start_ok && !Op[2];
    // Op 0 (MULT) and 2 (DIV) are the signed variants.
    assign signed_op = !Op[0];
    assign abs_x     = (signed_op && X[31]) ? (~X + 32'd1) : X;
    assign abs_y     = (signed_op && Y[31]) ? (~Y + 32'd1) : Y;

`ifdef MULDIV_FAST_MULT_EN
    logic        fast_req;
    logic [63:0] ext_x;
    logic [63:0] ext_y;
    logic [63:0] fast_prod;

    assign iter_req  = md_req && Op[1];
    assign fast_req  = md_req && !Op[1];
    // A 64-bit product of sign-extended operands, truncated to 64 bits,
    // equals the signed product; zero extension gives the unsigned one.
    assign ext_x     = {(signed_op ? {32{X[31]}} : 32'd0), X};
    assign ext_y     = {(signed_op ? {32{Y[31]}} : 32'd0), Y};
    assign fast_prod = ext_x * ext_y;
`else
    assign iter_req  = md_req;
`endif

    // ------------------------------------------------------------------------
    // One radix-2 step
    // ------------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [31:0] step_hi;
    logic [31:0] step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : 33'd0);
        div_shift = {acc_hi, acc_lo[31]};
        div_trial = div_shift - {1'b0, opnd_b};
        step_hi   = acc_hi;
        step_lo   = acc_lo;
        if (is_div) begin
            // Partial remainder is always below the divisor, so the 33-bit
            // trial only has bit 32 set when the subtraction borrowed.
            step_hi = div_trial[32] ? div_shift[31:0] : div_trial[31:0];
            step_lo = {acc_lo[30:0], !div_trial[32]};
        end else begin
            // Add-then-shift: the carry out of the add becomes the new MSB.
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], acc_lo[31:1]};
        end
    end

    // ------------------------------------------------------------------------
    // Sign correction applied in FIN
    // ------------------------------------------------------------------------
    logic [63:0] prod_mag;
    logic [63:0] prod_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        prod_mag = {acc_hi, acc_lo};
        prod_fix = neg_q ? (~prod_mag + 64'd1) : prod_mag;
        res_hi   = prod_fix[63:32];
        res_lo   = prod_fix[31:0];
        if (is_div) begin
            // Remainder follows the dividend's sign. With a zero divisor the
            // remainder magnitude equals |X|, so this restores X itself.
            res_hi = neg_r ? (~acc_hi + 32'd1) : acc_hi;
            if (div_zero) begin
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_lo = neg_q ? (~acc_lo + 32'd1) : acc_lo;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM and HI/LO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= 5'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
            opnd_b   <= 32'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iter_req) begin
                        state    <= ST_RUN;
                        Busy     <= 1'b1;
                        count    <= 5'd0;
                        is_div   <= Op[1];
                        neg_q    <= signed_op && (X[31] ^ Y[31]);
                        neg_r    <= signed_op && X[31];
                        div_zero <= Op[1] && (Y == 32'd0);
                        acc_hi   <= 32'd0;
                        // Multiply shifts the multiplier (|Y|) out of acc_lo
                        // and adds |X|; divide shifts |X| out of acc_lo.
                        acc_lo   <= Op[1] ? abs_x : abs_y;
                        opnd_b   <= Op[1] ? abs_y : abs_x;
                    end
`ifdef MULDIV_FAST_MULT_EN
                    else if (fast_req) begin
                        HI   <= fast_prod[63:32];
                        LO   <= fast_prod[31:0];
                        Done <= 1'b1;
                    end
`endif
                    else if (start_ok && (Op == OP_MTHI)) begin
                        HI <= X;
                    end else if (start_ok && (Op == OP_MTLO)) begin
                        LO <= X;
                    end
                end

                ST_RUN: begin
                    if (Flush) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        count  <= count + 5'd1;
                        if (count == 5'(ITER - 1)) begin
                            state <= ST_FIN;
                        end
                    end
                end

                ST_FIN: begin
                    // Flush wins over the result write.
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                    if (!Flush) begin
                        HI   <= res_hi;
                        LO   <= res_lo;
                        Done <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_hilo_unit
// Description : Self-checking bench for muldiv_hilo_unit. A vector table and
//               a few random operations are issued back to back; expected
//               HI/LO go into a scoreboard queue that a Done monitor pops.
//               Hand-written sequences cover MTHI/MTLO, reserved ops, Flush
//               (idle, mid-run, in FIN) and asynchronous reset mid-run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_hilo_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  op;
    logic        start;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    muldiv_hilo_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .X     (x),
        .Y     (y),
        .Op    (op),
        .Start (start),
        .Flush (flush),
        .Busy  (busy),
        .Done  (done),
        .HI    (hi),
        .LO    (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;

    // Edges counted from the accept edge E0 up to the edge that raises Done.
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model built from native 64-bit arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t           r;
        longint         sa, sb, q, m;
        longint unsigned ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        r.hi = 32'd0;
        r.lo = 32'd0;
        case (o)
            3'd0: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
            3'd1: begin p = ua * ub; r.hi = p[63:32]; r.lo = p[31:0]; end
            3'd2: begin
                if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
                else begin q = sa / sb; m = sa % sb; r.hi = m[31:0]; r.lo = q[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
                else begin p = ua / ub; q = ua % ub; r.hi = q[31:0]; r.lo = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    // Scoreboard: every Done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_hi", hi, e.hi);
                check("sb_lo", lo, e.lo);
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Called right after a negedge; returns at the negedge where Done is seen,
    // so a following call issues Start in the Done cycle (back-to-back).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int lat;
        int exp_lat;
        exp_lat = (o < 3'd2) ? MUL_LAT : DIV_LAT;
        start = 1'b1; op = o; x = a; y = b;
        sb_q.push_back(e);
        lat = 1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (exp_lat > 1) check("busy_running", 32'(busy), 32'd1);
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        if (done !== 1'b1) sb_q.delete();
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            check(name, 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    vec_t vt[13];

    initial begin
        exp_t e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  ro;

        vt[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vt[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vt[2]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vt[3]  = '{3'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
        vt[4]  = '{3'd3, 32'd100,       32'd7,          32'd2,         32'd14};
        vt[5]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vt[6]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vt[7]  = '{3'd3, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF};
        vt[8]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vt[9]  = '{3'd2, 32'hFFFF_FFF7, 32'd0,          32'hFFFF_FFF7, 32'hFFFF_FFFF};
        vt[10] = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'd1,         32'hFFFF_FFFE};
        vt[11] = '{3'd3, 32'hFFFF_FFFF, 32'd1,          32'd0,         32'hFFFF_FFFF};
        vt[12] = '{3'd2, 32'h8000_0000, 32'd2,          32'd0,         32'hC000_0000};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; x = 32'd0; y = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, issued back to back.
        for (int i = 0; i < 13; i++) begin
            e.hi = vt[i].hi;
            e.lo = vt[i].lo;
            run_op(vt[i].op, vt[i].x, vt[i].y, e);
        end

        // Random operations checked against the model.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i < 3) ? $urandom : $urandom_range(1, 300);
            ro = 3'($urandom_range(0, 3));
            e  = model(ro, ra, rb);
            run_op(ro, ra, rb, e);
        end

        // MTLO / MTHI when idle: write at the edge, no Done, no Busy.
        start = 1'b1; op = 3'd5; x = 32'h0000_ABCD;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h0000_ABCD);
        check("mtlo_done", 32'(done), 32'd0);
        check("mtlo_busy", 32'(busy), 32'd0);
        start = 1'b1; op = 3'd4; x = 32'h0000_5678;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        check("mthi_hi", hi, 32'h0000_5678);

        // Reserved op is ignored.
        start = 1'b1; op = 3'd6; x = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        check("rsvd_hi", hi, 32'h0000_5678);
        check("rsvd_lo", lo, 32'h0000_ABCD);
        check("rsvd_busy", 32'(busy), 32'd0);

        // Flush with Start in IDLE drops the request (MTLO and MULT).
        start = 1'b1; flush = 1'b1; op = 3'd5; x = 32'hFFFF_0000;
        @(posedge clk); @(negedge clk);
        check("flush_mtlo_lo", lo, 32'h0000_ABCD);
        op = 3'd0; x = 32'd9; y = 32'd9;
        @(posedge clk); @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_mult_busy", 32'(busy), 32'd0);
        check("flush_mult_hi", hi, 32'h0000_5678);
        repeat (3) @(negedge clk);

        // MTHI while busy is ignored; DIVU 1000/33 -> q=30 r=10.
        e.hi = 32'd10; e.lo = 32'd30;
        sb_q.push_back(e);
        start = 1'b1; op = 3'd3; x = 32'd1000; y = 32'd33;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd4; x = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        wait_done("mthi_busy_timeout");
        check("mthi_busy_hi", hi, 32'd10);
        @(negedge clk);

        // Flush at iteration 10 of DIVU 100/7: abort, HI/LO kept.
        start = 1'b1; op = 3'd3; x = 32'd100; y = 32'd7;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_run_busy", 32'(busy), 32'd0);
        check("flush_run_hi", hi, 32'd10);
        check("flush_run_lo", lo, 32'd30);
        repeat (40) @(negedge clk);
        e.hi = 32'd2; e.lo = 32'd14;
        run_op(3'd3, 32'd100, 32'd7, e);
        @(negedge clk);

        // Flush during FIN beats the result write.
        start = 1'b1; op = 3'd2; x = 32'd1000; y = 32'd33;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        check("fin_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_fin_busy", 32'(busy), 32'd0);
        check("flush_fin_done", 32'(done), 32'd0);
        check("flush_fin_hi", hi, 32'd2);
        check("flush_fin_lo", lo, 32'd14);
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-run clears everything at once.
        start = 1'b1; op = 3'd2; x = 32'd12345; y = 32'd17;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFFA;
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, e);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
